// File: rtl/bbus_skid_mux.sv
// -----------------------------------------------------------------------------
// bbus_skid_mux
//   Registered B-bus source multiplexer. Selects one of NUM_SRC register
//   sources and zero-extends narrow sources. The selected word is held in an
//   output register backed by a one-word skid register, so that producer and
//   consumer can stall independently without losing throughput.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   src_data     : packed sources, source k at [k*DATA_W-1 : (k-1)*DATA_W]
//   sel          : select code (0 = zero bus, >NUM_SRC = illegal, reads 0)
//   sel_valid    : select request valid
//   sel_ready    : block can accept a select (registered-state decode only)
//   bus_data     : registered B-bus value
//   bus_src      : raw select code that produced bus_data
//   bus_valid    : bus_data / bus_src valid
//   bus_ready    : consumer takes the current word
//   err_sel      : sticky flag, set by an accepted illegal select
//   err_clr      : clears err_sel (an illegal accept in the same cycle wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side (accept = sel_valid && sel_ready, pop = bus_valid &&
// bus_ready). Valid never depends on ready; once bus_valid is high,
// bus_data/bus_src hold until the word is popped.
// -----------------------------------------------------------------------------
module bbus_skid_mux #(
   parameter int                 DATA_W      = 16,
   parameter int                 NUM_SRC     = 9,
   parameter int                 SEL_W       = 4,
   parameter int                 NARROW_W    = 8,
   parameter logic [NUM_SRC-1:0] NARROW_MASK = 9'b000000111
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      sel_valid,
   output logic                      sel_ready,
   output logic [DATA_W-1:0]         bus_data,
   output logic [SEL_W-1:0]          bus_src,
   output logic                      bus_valid,
   input  logic                      bus_ready,
   output logic                      err_sel,
   input  logic                      err_clr
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] NARROW_KEEP = DATA_W'({NARROW_W{1'b1}});

   state_t              state;
   state_t              state_d;
   logic [DATA_W-1:0]   out_data;
   logic [SEL_W-1:0]    out_src;
   logic                out_valid;
   logic [DATA_W-1:0]   skid_data;
   logic [SEL_W-1:0]    skid_src;
   logic                err_q;
   logic                err_d;

   logic [DATA_W-1:0]   cap_data;
   logic                sel_illegal;
   logic                accept;
   logic                pop;
   logic                load_out_new;
   logic                load_out_skid;
   logic                load_skid;

   // Source selection. Codes 0 and >NUM_SRC match no source and read as 0.
   always_comb begin
      cap_data = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            cap_data = src_data[k*DATA_W-1 -: DATA_W];
            if (NARROW_MASK[k-1]) begin
               cap_data = cap_data & NARROW_KEEP;
            end
         end
      end
   end

   assign sel_illegal = (sel > SEL_W'(NUM_SRC));

   // sel_ready decodes registered state only: no path from bus_ready.
   assign sel_ready = (state != S_TWO);
   assign accept    = sel_valid && sel_ready;
   assign pop       = out_valid && bus_ready;

   // Occupancy FSM: next state and register load enables.
   always_comb begin
      state_d       = state;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      unique case (state)
         S_EMPTY: begin
            if (accept) begin
               load_out_new = 1'b1;
               state_d      = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && pop) begin
               load_out_new = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = S_TWO;
            end else if (pop) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (pop) begin
               load_out_skid = 1'b1;
               state_d       = S_ONE;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   // Set has priority over clear so an illegal accept is never lost.
   always_comb begin
      err_d = err_q;
      if (accept && sel_illegal) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_EMPTY;
         out_data  <= '0;
         out_src   <= '0;
         out_valid <= 1'b0;
         skid_data <= '0;
         skid_src  <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_d;
         // Kept as its own flop so bus_valid comes straight from a register.
         out_valid <= (state_d != S_EMPTY);
         err_q     <= err_d;
         if (load_out_new) begin
            out_data <= cap_data;
            out_src  <= sel;
         end else if (load_out_skid) begin
            out_data <= skid_data;
            out_src  <= skid_src;
         end
         if (load_skid) begin
            skid_data <= cap_data;
            skid_src  <= sel;
         end
      end
   end

   assign bus_data  = out_data;
   assign bus_src   = out_src;
   assign bus_valid = out_valid;
   assign err_sel   = err_q;

endmodule

// File: tb/tb_bbus_skid_mux.sv
// -----------------------------------------------------------------------------
// tb_bbus_skid_mux
//   Self-checking bench for bbus_skid_mux. Accepted selects push the expected
//   {bus_src, bus_data} word onto a queue; every cycle the head of the queue is
//   compared with the output while bus_valid is high, and popped on a pop.
// -----------------------------------------------------------------------------
module tb_bbus_skid_mux;

   localparam int DATA_W  = 16;
   localparam int NUM_SRC = 9;
   localparam int SEL_W   = 4;
   localparam logic [NUM_SRC-1:0] NARROW_MASK_TB = 9'b000000111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [SEL_W-1:0]          sel;
   logic                      sel_valid;
   logic                      sel_ready;
   logic [DATA_W-1:0]         bus_data;
   logic [SEL_W-1:0]          bus_src;
   logic                      bus_valid;
   logic                      bus_ready;
   logic                      err_sel;
   logic                      err_clr;

   bbus_skid_mux dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_data  (src_data),
      .sel       (sel),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .bus_data  (bus_data),
      .bus_src   (bus_src),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready),
      .err_sel   (err_sel),
      .err_clr   (err_clr)
   );

   // ---------------- scoreboard ----------------
   logic [SEL_W+DATA_W-1:0] exp_q[$];
   logic                    err_exp;
   logic                    last_acc;
   int                      n_checks;
   int                      n_pass;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [SEL_W+DATA_W-1:0] model(input logic [SEL_W-1:0] s,
                                                     input logic [NUM_SRC*DATA_W-1:0] src);
      logic [DATA_W-1:0] d;
      d = '0;
      if (s >= 1 && s <= NUM_SRC) begin
         d = src[(int'(s)-1)*DATA_W +: DATA_W];
         if (NARROW_MASK_TB[int'(s)-1]) d = {8'h00, d[7:0]};
      end
      return {s, d};
   endfunction

   task automatic set_src(input int k, input logic [DATA_W-1:0] v);
      src_data[(k-1)*DATA_W +: DATA_W] = v;
   endtask

   // One clock cycle: check outputs against the model at the falling edge,
   // update the model with that cycle's handshakes, return at posedge+1.
   task automatic step();
      logic acc;
      logic pop;
      logic err_n;
      @(negedge clk);
      check_eq("bus_valid", bus_valid, exp_q.size() != 0);
      check_eq("sel_ready", sel_ready, exp_q.size() < 2);
      check_eq("err_sel", err_sel, err_exp);
      if (bus_valid && exp_q.size() != 0)
         check_eq("word", {bus_src, bus_data}, exp_q[0]);
      acc = sel_valid && sel_ready;
      pop = bus_valid && bus_ready;
      err_n = err_exp;
      if (acc && sel > NUM_SRC) err_n = 1'b1;
      else if (err_clr) err_n = 1'b0;
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model(sel, src_data));
      last_acc = acc;
      @(posedge clk);
      #1;
      err_exp = err_n;
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic [SEL_W-1:0] s, output int waits);
      sel       = s;
      sel_valid = 1'b1;
      waits     = 0;
      last_acc  = 1'b0;
      while (!last_acc && waits < 20) begin
         step();
         if (!last_acc) waits++;
      end
      if (!last_acc) check_eq("send_timeout", 0, 1);
      sel_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      sel_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, bus_valid, 0);
      check_eq({tag, "_ready"}, sel_ready, 1);
      check_eq({tag, "_data"}, bus_data, 0);
      check_eq({tag, "_src"}, bus_src, 0);
      check_eq({tag, "_err"}, err_sel, 0);
   endtask

   initial begin
      int w;
      n_checks  = 0;
      n_pass    = 0;
      err_exp   = 1'b0;
      last_acc  = 1'b0;
      rst_n     = 1'b0;
      src_data  = '0;
      sel       = '0;
      sel_valid = 1'b0;
      bus_ready = 1'b0;
      err_clr   = 1'b0;

      #12;
      check_reset_outputs("rst");
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: back-to-back 1, 4, 9 with one-cycle latency
      set_src(1, 16'hABCD);
      set_src(4, 16'h1234);
      set_src(9, 16'hBEEF);
      bus_ready = 1'b1;
      send(4'd1, w);
      check_eq("t1_wait1", w, 0);
      check_eq("t1_data1", {bus_valid, bus_src, bus_data}, {1'b1, 4'd1, 16'h00CD});
      send(4'd4, w);
      check_eq("t1_data4", {bus_valid, bus_src, bus_data}, {1'b1, 4'd4, 16'h1234});
      send(4'd9, w);
      check_eq("t1_data9", {bus_valid, bus_src, bus_data}, {1'b1, 4'd9, 16'hBEEF});
      idle(2);

      // 2: stall fills OUT+SKID, third select waits until sel_ready returns
      set_src(5, 16'h0005);
      set_src(6, 16'h0006);
      set_src(7, 16'h0007);
      bus_ready = 1'b0;
      send(4'd5, w);
      send(4'd6, w);
      check_eq("t2_full", sel_ready, 0);
      sel = 4'd7;
      sel_valid = 1'b1;
      step();
      check_eq("t2_held", last_acc, 0);
      check_eq("t2_stable", bus_data, 16'h0005);
      bus_ready = 1'b1;
      send(4'd7, w);
      check_eq("t2_wait7", w, 1);
      idle(3);

      // 3: zero select, illegal select, err_clr vs. set priority
      send(4'd0, w);
      check_eq("t3_sel0", {bus_src, bus_data}, {4'd0, 16'h0000});
      send(4'd12, w);
      check_eq("t3_sel12", {bus_src, bus_data}, {4'd12, 16'h0000});
      check_eq("t3_err_set", err_sel, 1);
      err_clr = 1'b1;
      send(4'd13, w);
      check_eq("t3_err_prio", err_sel, 1);
      step();
      err_clr = 1'b0;
      check_eq("t3_err_clr", err_sel, 0);
      idle(2);

      // 4: narrow masking
      set_src(2, 16'hFFFF);
      set_src(8, 16'hFFFF);
      send(4'd2, w);
      check_eq("t4_narrow", bus_data, 16'h00FF);
      send(4'd8, w);
      check_eq("t4_wide", bus_data, 16'hFFFF);
      idle(2);

      // 5: asynchronous reset in TWO with err_sel set
      bus_ready = 1'b0;
      send(4'd12, w);
      send(4'd1, w);
      check_eq("t5_two", sel_ready, 0);
      check_eq("t5_err", err_sel, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_async");
      exp_q.delete();
      err_exp = 1'b0;
      @(posedge clk);
      #3;
      check_reset_outputs("t5_hold");
      rst_n = 1'b1;
      bus_ready = 1'b1;
      idle(3);

      // 6: random traffic against the queue model
      for (int c = 0; c < 10000; c++) begin
         for (int k = 1; k <= NUM_SRC; k++) set_src(k, DATA_W'($urandom));
         sel       = SEL_W'($urandom_range(0, 15));
         sel_valid = ($urandom_range(0, 3) != 0);
         bus_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 7) == 0);
         step();
      end
      sel_valid = 1'b0;
      err_clr   = 1'b0;
      bus_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bbus_skid_mux.md
# bbus_skid_mux

Parametrised, registered successor to the datapath B-bus source multiplexer. It selects one of `NUM_SRC` register sources onto the B bus and zero-extends narrow (8-bit) sources. It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the control unit and ALU can stall independently. Out-of-range selects are flagged with a sticky error.

## Interface
Parameters
- `DATA_W`, 16: bus width.
- `NUM_SRC`, 9: number of sources; select code k (1..NUM_SRC) picks source k.
- `SEL_W`, 4: select width; must satisfy 2^SEL_W > NUM_SRC.
- `NARROW_W`, 8: width of narrow sources.
- `NARROW_MASK`, 9'b000000111: bit k-1 set means source k is narrow (MDR, PC, MBRU by default).

Ports
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `src_data`  in  NUM_SRC*DATA_W: packed sources; source k occupies bits [k*DATA_W-1 : (k-1)*DATA_W].
- `sel`  in  SEL_W: select code. 0 means zero bus.
- `sel_valid`  in  1: select request valid.
- `sel_ready`  out  1: block can accept a select.
- `bus_data`  out  DATA_W: registered B-bus value.
- `bus_src`  out  SEL_W: select code that produced `bus_data`.
- `bus_valid`  out  1: `bus_data`/`bus_src` valid.
- `bus_ready`  in  1: consumer accepts the current word.
- `err_sel`  out  1: sticky flag, set when an out-of-range select is accepted.
- `err_clr`  in  1: clears `err_sel`.

## Operation
- Accept occurs when `sel_valid && sel_ready`. On accept, `src_data` and `sel` are sampled in the same cycle.
- Captured value by select code:
  - sel = 0: value is 0.
  - 1 ≤ sel ≤ NUM_SRC: value is source sel. If that source is narrow, the value is `{zeros, src[NARROW_W-1:0]}`, with upper bits forced to 0 regardless of input.
  - sel > NUM_SRC: value is 0 and `err_sel` is set.
- `bus_src` always carries the raw accepted `sel`, including illegal codes.
- Storage is an output register (OUT) plus a skid register (SKID). Occupancy states:
  - EMPTY: `bus_valid`=0, `sel_ready`=1.
    - accept → ONE.
  - ONE: `bus_valid`=1, `sel_ready`=1.
    - accept without pop → TWO; new word goes to SKID.
    - pop without accept → EMPTY.
    - accept and pop together → stays ONE; OUT is loaded with the new word.
  - TWO: `bus_valid`=1, `sel_ready`=0.
    - pop → ONE; SKID moves to OUT.
    - no accept is possible in this state.
- Pop occurs when `bus_valid && bus_ready`.
- Words leave strictly in FIFO order; no word is dropped or duplicated.
- `err_sel` rules:
  - set by an illegal accept, cleared by `err_clr`.
  - if both happen in the same cycle, set wins.
  - not affected by pops.
- Reset, including mid-transfer: state goes to EMPTY and `bus_data`=0, `bus_src`=0, `bus_valid`=0, `err_sel`=0, `sel_ready`=1 (while reset is asserted and after release). Any in-flight word is discarded.

## Timing
- Latency: a word accepted at edge n appears on `bus_data` with `bus_valid`=1 after edge n when entering from EMPTY. From ONE or TWO it appears once all older words have popped.
- Throughput: one word per cycle sustained while `bus_ready`=1.
- `sel_ready` is a pure function of registered state (not TWO). There is no combinational path from `bus_ready` to `sel_ready`.
- `bus_data`, `bus_src`, and `bus_valid` are driven directly from flops. They are stable while `bus_valid`=1 and `bus_ready`=0.
- `src_data` needs only setup/hold around the accept edge; it is not sampled at any other time.
- `err_sel` is visible the cycle after the illegal accept.

## Test plan
1. Reset, then back-to-back selects 1, 4, 9 with `bus_ready`=1. Sources: src1=16'hABCD, src4=16'h1234, src9=16'hBEEF. Required: `bus_data` 16'h00CD, 16'h1234, 16'hBEEF on consecutive cycles; `bus_src` 1, 4, 9; 1-cycle latency.
2. Hold `bus_ready`=0 and offer selects 5, 6, 7 with src5=16'h0005, src6=16'h0006, src7=16'h0007.
   - After the 2nd accept, `sel_ready`=0 and sel 7 waits.
   - Release `bus_ready`: pops are 16'h0005, 16'h0006, 16'h0007 in order, and sel 7 is accepted the cycle `sel_ready` returns.
3. Select 0 and then select 12 (illegal). Required: `bus_data`=0 both times, `bus_src`=0 then 12, `err_sel`=1 the cycle after the select-12 accept. Asserting `err_clr` together with another illegal accept leaves `err_sel`=1; a subsequent `err_clr` alone clears it.
4. Narrow-source masking: src2=16'hFFFF, src8=16'hFFFF. Required: select 2 yields 16'h00FF; select 8 yields 16'hFFFF.
5. With state TWO and `err_sel`=1, assert `rst_n`=0 for 1 cycle asynchronously, mid-cycle. Required: all outputs go to reset values immediately, `sel_ready`=1, and no stale word appears after release.
6. Random `sel_valid`/`bus_ready` for 10k cycles, checked against a reference queue model. Required: no loss, duplication or reordering; `bus_data` is stable whenever stalled.
